// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back cache.
//   - FSM state encoding (localparams plus the typed enum built on them)
//   - Address field helper constants
//   - Write policy constants, also used by the arbiter bench
package cache_pkg;

    // Byte offset inside a one-word line; these address bits are ignored.
    localparam int unsigned OFFSET_W = 2;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_WB      = 3'd1;
    localparam logic [STATE_W-1:0] ST_FILL    = 3'd2;
    localparam logic [STATE_W-1:0] ST_WT      = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;
    localparam logic [STATE_W-1:0] ST_RELEASE = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        StIdle    = ST_IDLE,
        StWb      = ST_WB,
        StFill    = ST_FILL,
        StWt      = ST_WT,
        StDone    = ST_DONE,
        StRelease = ST_RELEASE
    } state_e;

    localparam bit POLICY_WRITE_BACK    = 1'b1;
    localparam bit POLICY_WRITE_THROUGH = 1'b0;

endpackage

// File: rtl/cache_tag_ram.sv
// Tag, valid and dirty storage for the direct-mapped cache.
// Single port addressed by index; lookup is combinational.
//   clk, rst    : clock, asynchronous active-high reset (clears valid/dirty only)
//   index, tag  : line index and request tag
//   install     : write tag and set valid for the indexed line
//   dirty_we    : write dirty_in into the indexed line's dirty bit
//   hit         : valid and stored tag matches
//   line_valid, line_dirty, line_tag : current contents of the indexed line
module cache_tag_ram
    import cache_pkg::*;
#(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned TAG_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    input  logic               install,
    input  logic               dirty_we,
    input  logic               dirty_in,
    output logic               hit,
    output logic               line_valid,
    output logic               line_dirty,
    output logic [TAG_W-1:0]   line_tag
);

    localparam int unsigned LINES = 2 ** INDEX_W;

    logic [TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;

    // Tags are not reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[index] <= tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (install) begin
                valid_q[index] <= 1'b1;
            end
            if (dirty_we) begin
                dirty_q[index] <= dirty_in;
            end
        end
    end

    assign line_valid = valid_q[index];
    assign line_dirty = dirty_q[index];
    assign line_tag   = tag_q[index];
    assign hit        = line_valid && (line_tag == tag);

endmodule

// File: rtl/cache_dm_wb.sv
// Direct-mapped, single-word-line cache between the CPU and the memory arbiter.
// WRITE_BACK=1 selects write-back/write-allocate with victim write-back;
// WRITE_BACK=0 selects write-through/no-write-allocate.
//   CPU side   : read, write, adbus, wdata -> rdata, ready (one-cycle pulse)
//   Memory side: read_mem, write_mem, mem_adbus, mem_wdata -> arbiter;
//                grant_mem, ready_mem, mem_rdata <- arbiter
//   Statistics : hit_count, miss_count (saturating)
module cache_dm_wb
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned INDEX_W    = 6,
    parameter bit          WRITE_BACK = POLICY_WRITE_BACK,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] adbus,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              read_mem,
    output logic              write_mem,
    input  logic              grant_mem,
    input  logic              ready_mem,
    output logic [ADDR_W-1:0] mem_adbus,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINES = 2 ** INDEX_W;

    state_e state_q, state_d;

    logic              is_read_q, is_read_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              read_mem_q, read_mem_d;
    logic              write_mem_q, write_mem_d;
    logic [ADDR_W-1:0] mem_adbus_q, mem_adbus_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

    logic [DATA_W-1:0] data_q [LINES];

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               unused_offset;

    logic               hit, line_valid, line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic               install, dirty_we, dirty_in;
    logic               data_we;
    logic [DATA_W-1:0]  data_wdata;
    logic               hit_inc, miss_inc;
    logic               mem_accept, victim_dirty;
    logic [ADDR_W-1:0]  req_addr, victim_addr;

    assign index         = adbus[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign tag           = adbus[ADDR_W-1:INDEX_W+OFFSET_W];
    assign unused_offset = ^adbus[OFFSET_W-1:0];

    assign req_addr     = {tag, index, {OFFSET_W{1'b0}}};
    assign victim_addr  = {line_tag, index, {OFFSET_W{1'b0}}};
    assign mem_accept   = grant_mem && ready_mem;
    assign victim_dirty = WRITE_BACK && line_valid && line_dirty;

    cache_tag_ram #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_ram (
        .clk        (clk),
        .rst        (rst),
        .index      (index),
        .tag        (tag),
        .install    (install),
        .dirty_we   (dirty_we),
        .dirty_in   (dirty_in),
        .hit        (hit),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag)
    );

    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        rdata_d     = rdata_q;
        read_mem_d  = read_mem_q;
        write_mem_d = write_mem_q;
        mem_adbus_d = mem_adbus_q;
        mem_wdata_d = mem_wdata_q;
        install     = 1'b0;
        dirty_we    = 1'b0;
        dirty_in    = 1'b0;
        data_we     = 1'b0;
        data_wdata  = wdata;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (read || write) begin
                    // Read wins when both are raised; the write is dropped.
                    is_read_d = read;
                    hit_inc   = hit;
                    miss_inc  = !hit;
                    if (read) begin
                        if (hit) begin
                            rdata_d = data_q[index];
                            state_d = StDone;
                        end else if (victim_dirty) begin
                            write_mem_d = 1'b1;
                            mem_adbus_d = victim_addr;
                            mem_wdata_d = data_q[index];
                            state_d     = StWb;
                        end else begin
                            read_mem_d  = 1'b1;
                            mem_adbus_d = req_addr;
                            state_d     = StFill;
                        end
                    end else if (WRITE_BACK) begin
                        if (!hit && victim_dirty) begin
                            write_mem_d = 1'b1;
                            mem_adbus_d = victim_addr;
                            mem_wdata_d = data_q[index];
                            state_d     = StWb;
                        end else begin
                            // One-word lines: allocation needs no fill.
                            install  = !hit;
                            data_we  = 1'b1;
                            dirty_we = 1'b1;
                            dirty_in = 1'b1;
                            state_d  = StDone;
                        end
                    end else begin
                        data_we     = hit;
                        write_mem_d = 1'b1;
                        mem_adbus_d = req_addr;
                        mem_wdata_d = wdata;
                        state_d     = StWt;
                    end
                end
            end
            StWb: begin
                if (mem_accept) begin
                    write_mem_d = 1'b0;
                    dirty_we    = 1'b1;
                    dirty_in    = 1'b0;
                    if (is_read_q) begin
                        read_mem_d  = 1'b1;
                        mem_adbus_d = req_addr;
                        state_d     = StFill;
                    end else begin
                        install  = 1'b1;
                        data_we  = 1'b1;
                        dirty_in = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StFill: begin
                if (mem_accept) begin
                    read_mem_d = 1'b0;
                    data_we    = 1'b1;
                    data_wdata = mem_rdata;
                    rdata_d    = mem_rdata;
                    install    = 1'b1;
                    dirty_we   = 1'b1;
                    dirty_in   = 1'b0;
                    state_d    = StDone;
                end
            end
            StWt: begin
                if (mem_accept) begin
                    write_mem_d = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StRelease;
            end
            StRelease: begin
                // Wait for the CPU to drop its request so it is not serviced twice.
                if (!read && !write) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            is_read_q   <= 1'b0;
            rdata_q     <= '0;
            read_mem_q  <= 1'b0;
            write_mem_q <= 1'b0;
            mem_adbus_q <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            rdata_q     <= rdata_d;
            read_mem_q  <= read_mem_d;
            write_mem_q <= write_mem_d;
            mem_adbus_q <= mem_adbus_d;
            mem_wdata_q <= mem_wdata_d;
            if (hit_inc && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
            if (miss_inc && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
        end
    end

    // Data array is not reset; valid bits gate its use.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[index] <= data_wdata;
        end
    end

    assign ready      = (state_q == StDone);
    assign rdata      = rdata_q;
    assign read_mem   = read_mem_q;
    assign write_mem  = write_mem_q;
    assign mem_adbus  = mem_adbus_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_dm_wb.sv
// Bench for cache_dm_wb: instance 0 is write-back (16-bit counters), instance 1
// is write-through with 4-bit counters so saturation is reachable. A line-level
// cache model plus a flat memory array predict hits, read data, counters and the
// ordered list of memory transfers for every CPU access.
module tb_cache_dm_wb;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    logic        clk, rst;
    logic        rd [2];
    logic        wr [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        read_mem [2];
    logic        write_mem [2];
    logic        grant [2];
    logic        rmem [2];
    logic [31:0] mem_ad [2];
    logic [31:0] mem_wd [2];
    logic [31:0] mem_rd [2];
    logic [15:0] hc0, mc0;
    logic [3:0]  hc1, mc1;
    logic [15:0] hcnt [2];
    logic [15:0] mcnt [2];

    // Environment memory (word addressed) and the bench's cache model.
    logic [31:0] mem [2][1024];
    bit          mv [2][64];
    bit          mdirty [2][64];
    logic [23:0] mt [2][64];
    logic [31:0] md [2][64];
    int          mhits [2];
    int          mmiss [2];

    op_t         q0 [$];
    op_t         q1 [$];
    bit          busy [2];
    bit          exp_read [2];
    logic [31:0] exp_rdata [2];
    int          exp_hits [2];
    int          exp_miss [2];
    int          mode [2];
    int          n_wr [2];
    int          n_rd [2];
    logic [31:0] last_wr_addr [2];
    logic [31:0] last_wr_data [2];
    logic [31:0] last_rd_addr [2];
    logic [31:0] last_rdata [2];

    int total = 0;
    int bad   = 0;

    cache_dm_wb #(
        .WRITE_BACK (1'b1),
        .CNT_W      (16)
    ) u_wb (
        .clk        (clk),
        .rst        (rst),
        .read       (rd[0]),
        .write      (wr[0]),
        .adbus      (ad[0]),
        .wdata      (wd[0]),
        .rdata      (rdata[0]),
        .ready      (ready[0]),
        .read_mem   (read_mem[0]),
        .write_mem  (write_mem[0]),
        .grant_mem  (grant[0]),
        .ready_mem  (rmem[0]),
        .mem_adbus  (mem_ad[0]),
        .mem_wdata  (mem_wd[0]),
        .mem_rdata  (mem_rd[0]),
        .hit_count  (hc0),
        .miss_count (mc0)
    );

    cache_dm_wb #(
        .WRITE_BACK (1'b0),
        .CNT_W      (4)
    ) u_wt (
        .clk        (clk),
        .rst        (rst),
        .read       (rd[1]),
        .write      (wr[1]),
        .adbus      (ad[1]),
        .wdata      (wd[1]),
        .rdata      (rdata[1]),
        .ready      (ready[1]),
        .read_mem   (read_mem[1]),
        .write_mem  (write_mem[1]),
        .grant_mem  (grant[1]),
        .ready_mem  (rmem[1]),
        .mem_adbus  (mem_ad[1]),
        .mem_wdata  (mem_wd[1]),
        .mem_rdata  (mem_rd[1]),
        .hit_count  (hc1),
        .miss_count (mc1)
    );

    assign hcnt[0]   = hc0;
    assign mcnt[0]   = mc0;
    assign hcnt[1]   = {12'b0, hc1};
    assign mcnt[1]   = {12'b0, mc1};
    assign mem_rd[0] = mem[0][mem_ad[0][11:2]];
    assign mem_rd[1] = mem[1][mem_ad[1][11:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void qpush(input int i, input op_t o);
        if (i == 0) q0.push_back(o);
        else        q1.push_back(o);
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic op_t qfront(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    function automatic int sat(input int i, input int v);
        int lim;
        lim = (i == 0) ? 65535 : 15;
        return (v > lim) ? lim : v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int l = 0; l < 64; l++) begin
                mv[i][l]     = 1'b0;
                mdirty[i][l] = 1'b0;
            end
            mhits[i]    = 0;
            mmiss[i]    = 0;
            exp_hits[i] = 0;
            exp_miss[i] = 0;
            busy[i]     = 1'b0;
        end
        q0.delete();
        q1.delete();
    endfunction

    // Instance 0 follows write-back/allocate rules, instance 1 write-through.
    function automatic void model_txn(input int i, input bit is_rd, input logic [31:0] addr,
                                      input logic [31:0] data);
        int          idx;
        logic [23:0] tg;
        logic [31:0] waddr;
        bit          h;
        op_t         o;
        idx   = int'(addr[7:2]);
        tg    = addr[31:8];
        waddr = {addr[31:2], 2'b00};
        h     = mv[i][idx] && (mt[i][idx] == tg);
        if (h) mhits[i]++;
        else   mmiss[i]++;
        exp_read[i] = is_rd;
        if (is_rd) begin
            if (h) begin
                exp_rdata[i] = md[i][idx];
            end else begin
                if (i == 0 && mv[i][idx] && mdirty[i][idx]) begin
                    o = '{wr: 1'b1, addr: {mt[i][idx], idx[5:0], 2'b00}, data: md[i][idx]};
                    qpush(i, o);
                end
                o = '{wr: 1'b0, addr: waddr, data: 32'h0};
                qpush(i, o);
                exp_rdata[i]  = mem[i][waddr[11:2]];
                mv[i][idx]    = 1'b1;
                mt[i][idx]    = tg;
                md[i][idx]    = exp_rdata[i];
                mdirty[i][idx] = 1'b0;
            end
        end else if (i == 0) begin
            if (!h && mv[i][idx] && mdirty[i][idx]) begin
                o = '{wr: 1'b1, addr: {mt[i][idx], idx[5:0], 2'b00}, data: md[i][idx]};
                qpush(i, o);
            end
            mv[i][idx]     = 1'b1;
            mt[i][idx]     = tg;
            md[i][idx]     = data;
            mdirty[i][idx] = 1'b1;
        end else begin
            if (h) md[i][idx] = data;
            o = '{wr: 1'b1, addr: waddr, data: data};
            qpush(i, o);
        end
        exp_hits[i] = sat(i, mhits[i]);
        exp_miss[i] = sat(i, mmiss[i]);
    endfunction

    // Memory/arbiter responder: random grant and ready, a stall mode where
    // ready_mem pulses without grant, and a mode that grants at once.
    initial begin
        for (int i = 0; i < 2; i++) begin
            grant[i] = 1'b0;
            rmem[i]  = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                case (mode[i])
                    0: begin
                        grant[i] = ($urandom % 4) != 0;
                        rmem[i]  = ($urandom % 3) == 0;
                    end
                    1: begin
                        grant[i] = 1'b0;
                        rmem[i]  = ~rmem[i];
                    end
                    default: begin
                        grant[i] = 1'b1;
                        rmem[i]  = 1'b1;
                    end
                endcase
            end
        end
    end

    // Compare process: every cycle, check memory requests against the expected
    // transfer list and the completion pulse against the model.
    always @(negedge clk) begin
        op_t o;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (ready[i]) begin
                    if (!busy[i]) begin
                        check("ready_without_request", 32'(ready[i]), 32'h0);
                    end else begin
                        check("transfers_left_at_ready", qsize(i), 0);
                        if (exp_read[i]) check("rdata", rdata[i], exp_rdata[i]);
                        check("hit_count", 32'(hcnt[i]), exp_hits[i]);
                        check("miss_count", 32'(mcnt[i]), exp_miss[i]);
                        last_rdata[i] = rdata[i];
                        busy[i] = 1'b0;
                    end
                end
                if (read_mem[i] || write_mem[i]) begin
                    if (qsize(i) == 0) begin
                        check("unexpected_mem_request", {read_mem[i], write_mem[i]}, 32'h0);
                    end else begin
                        o = qfront(i);
                        check("mem_both_requests", 32'(read_mem[i] & write_mem[i]), 32'h0);
                        check("mem_request_kind", 32'(write_mem[i]), 32'(o.wr));
                        check("mem_adbus", mem_ad[i], o.addr);
                        if (o.wr) check("mem_wdata", mem_wd[i], o.data);
                        if (grant[i] && rmem[i]) begin
                            qpop(i);
                            if (write_mem[i]) begin
                                n_wr[i]++;
                                last_wr_addr[i] = mem_ad[i];
                                last_wr_data[i] = mem_wd[i];
                                mem[i][mem_ad[i][11:2]] = mem_wd[i];
                            end else begin
                                n_rd[i]++;
                                last_rd_addr[i] = mem_ad[i];
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic txn(input int i, input bit is_rd, input bit both, input logic [31:0] addr,
                       input logic [31:0] data, input int hold, input bit stall);
        int lat;
        bit done;
        int nops;
        model_txn(i, is_rd, addr, data);
        nops = qsize(i);
        if (stall) mode[i] = 1;
        @(posedge clk);
        #1;
        rd[i]   = is_rd;
        wr[i]   = !is_rd || both;
        ad[i]   = addr;
        wd[i]   = data;
        busy[i] = 1'b1;
        @(posedge clk);
        lat  = 0;
        done = 1'b0;
        if (stall) begin
            repeat (8) begin
                @(negedge clk);
                check("stall_no_ready", 32'(ready[i]), 32'h0);
            end
            lat     = 8;
            mode[i] = 2;
        end
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
            if (ready[i]) done = 1'b1;
        end
        if (!done) begin
            check("ready_timeout", 32'(ready[i]), 32'h1);
            busy[i] = 1'b0;
            if (i == 0) q0.delete();
            else        q1.delete();
        end else if (nops == 0) begin
            check("no_mem_latency", lat, 1);
        end
        repeat (hold) begin
            @(negedge clk);
            check("held_no_second_ready", 32'(ready[i]), 32'h0);
        end
        @(posedge clk);
        #1;
        rd[i]   = 1'b0;
        wr[i]   = 1'b0;
        mode[i] = 0;
    endtask

    initial begin
        int          wr_before;
        int          rd_before;
        bit          seen;
        op_t         o;
        logic [31:0] a;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd[i]   = 1'b0;
            wr[i]   = 1'b0;
            ad[i]   = '0;
            wd[i]   = '0;
            mode[i] = 0;
            n_wr[i] = 0;
            n_rd[i] = 0;
            last_wr_addr[i] = '0;
            last_wr_data[i] = '0;
            last_rd_addr[i] = '0;
            last_rdata[i]   = '0;
            for (int w = 0; w < 1024; w++) mem[i][w] = $urandom;
        end
        mem[0][32'h100 >> 2] = 32'h1234_5678;
        mem[0][32'h200 >> 2] = 32'hA5A5_0200;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_ready", 32'(ready[i]), 32'h0);
            check("reset_read_mem", 32'(read_mem[i]), 32'h0);
            check("reset_write_mem", 32'(write_mem[i]), 32'h0);
            check("reset_rdata", rdata[i], 32'h0);
            check("reset_mem_adbus", mem_ad[i], 32'h0);
            check("reset_mem_wdata", mem_wd[i], 32'h0);
            check("reset_hit_count", 32'(hcnt[i]), 32'h0);
            check("reset_miss_count", 32'(mcnt[i]), 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold write-allocate misses: no memory traffic.
        for (int k = 0; k < 8; k++) begin
            a = 32'(k * 4);
            txn(0, 1'b0, 1'b0, a, a, 0, 1'b0);
        end
        check("t1_miss_count", 32'(mcnt[0]), 32'd8);
        check("t1_mem_traffic", n_wr[0] + n_rd[0], 0);

        // Read hits of the same lines.
        for (int k = 0; k < 8; k++) begin
            a = 32'(k * 4);
            txn(0, 1'b1, 1'b0, a, 32'h0, 0, 1'b0);
        end
        check("t2_hit_count", 32'(hcnt[0]), 32'd8);
        check("t2_last_rdata", last_rdata[0], 32'h1C);
        check("t2_mem_traffic", n_wr[0] + n_rd[0], 0);

        // Conflict on index 0 with a dirty victim: write-back then fill.
        wr_before = n_wr[0];
        txn(0, 1'b1, 1'b0, 32'h100, 32'h0, 0, 1'b0);
        check("t3_victim_writes", n_wr[0] - wr_before, 1);
        check("t3_victim_addr", last_wr_addr[0], 32'h0);
        check("t3_victim_data", last_wr_data[0], 32'h0);
        check("t3_fill_addr", last_rd_addr[0], 32'h100);
        check("t3_rdata", last_rdata[0], 32'h1234_5678);

        // Fill with ready_mem pulsing but no grant, then grant; request held after ready.
        wr_before = n_wr[0];
        txn(0, 1'b1, 1'b0, 32'h200, 32'h0, 5, 1'b1);
        check("t5_clean_victim_no_write", n_wr[0] - wr_before, 0);
        check("t5_fill_addr", last_rd_addr[0], 32'h200);
        check("t5_rdata", last_rdata[0], 32'hA5A5_0200);

        // Write-through miss does not allocate; the read afterwards fills.
        txn(1, 1'b0, 1'b0, 32'h4, 32'hDEAD, 0, 1'b0);
        check("t4_wt_addr", last_wr_addr[1], 32'h4);
        check("t4_wt_data", last_wr_data[1], 32'hDEAD);
        check("t4_wt_no_read", n_rd[1], 0);
        txn(1, 1'b1, 1'b0, 32'h4, 32'h0, 0, 1'b0);
        check("t4_fill_addr", last_rd_addr[1], 32'h4);
        check("t4_rdata", last_rdata[1], 32'hDEAD);
        check("t4_miss_count", 32'(mcnt[1]), 32'd2);

        // Reset while a victim write is pending.
        txn(0, 1'b0, 1'b0, 32'h300, 32'h3333, 0, 1'b0);
        o = '{wr: 1'b1, addr: 32'h300, data: 32'h3333};
        qpush(0, o);
        exp_read[0] = 1'b1;
        busy[0]     = 1'b1;
        mode[0]     = 1;
        @(posedge clk);
        #1;
        rd[0] = 1'b1;
        ad[0] = 32'h0;
        seen  = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (write_mem[0]) seen = 1'b1;
        end
        check("t6_wb_started", 32'(write_mem[0]), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_write_mem", 32'(write_mem[0]), 32'h0);
        check("t6_async_read_mem", 32'(read_mem[0]), 32'h0);
        check("t6_async_ready", 32'(ready[0]), 32'h0);
        check("t6_async_miss_count", 32'(mcnt[0]), 32'h0);
        model_reset();
        mode[0] = 0;
        rd[0]   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wr_before = n_wr[0];
        rd_before = n_rd[0];
        txn(0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        check("t6_read_misses", 32'(mcnt[0]), 32'd1);
        check("t6_no_hit", 32'(hcnt[0]), 32'd0);
        check("t6_no_victim_write", n_wr[0] - wr_before, 0);
        check("t6_fill_count", n_rd[0] - rd_before, 1);

        // Randomised traffic on both policies, including read+write together.
        for (int n = 0; n < 200; n++) begin
            a = 32'($urandom_range(0, 1023));
            txn(0, 1'($urandom % 2), 1'($urandom % 4 == 0), a, $urandom, $urandom % 3, 1'b0);
        end
        for (int n = 0; n < 150; n++) begin
            a = 32'($urandom_range(0, 1023));
            txn(1, 1'($urandom % 2), 1'($urandom % 4 == 0), a, $urandom, $urandom % 3, 1'b0);
        end
        check("wt_miss_saturated", 32'(mcnt[1]), 32'd15);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_dm_wb.md
Name: cache_dm_wb

Overview:
Parametrised direct-mapped, single-word-line cache between the CPU port and the shared memory arbiter. It is the successor to the baseline write-through cache. It adds a configurable depth and width, a selectable write-back/write-allocate policy with dirty tracking and victim write-back, split CPU data buses, and saturating hit/miss counters. The memory side uses the existing request/grant/ready handshake toward the arbiter.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width
INDEX_W, 6, log2(number of lines); line count = 2**INDEX_W
WRITE_BACK, 1, 1 = write-back/write-allocate; 0 = write-through/no-write-allocate
CNT_W, 16, width of the hit/miss counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
read  in  1  CPU read request, held until ready
write  in  1  CPU write request, held until ready
adbus  in  ADDR_W  CPU byte address; bits [1:0] ignored
wdata  in  DATA_W  CPU write data
rdata  out  DATA_W  CPU read data, valid while ready=1
ready  out  1  one-cycle completion pulse
read_mem  out  1  memory read request to the arbiter
write_mem  out  1  memory write request to the arbiter
grant_mem  in  1  arbiter grant for this requester
ready_mem  in  1  memory transfer complete; honoured only while grant_mem=1
mem_adbus  out  ADDR_W  memory word address, {tag,index,2'b00}
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, captured when ready_mem&grant_mem
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Address split: index = adbus[INDEX_W+1:2]; tag = adbus[ADDR_W-1:INDEX_W+2].
- hit = valid[index] & (tag_ram[index] == tag).
- Reset (async): state=IDLE; all valid and dirty bits = 0; ready, read_mem, write_mem = 0; rdata, mem_adbus, mem_wdata = 0; counters = 0. The data and tag arrays are not reset.
- Reset mid-operation drops memory requests immediately. Any in-flight CPU access is lost.
- States: IDLE, WB (victim write), FILL (memory read), WT (write-through memory write), DONE, RELEASE.
- IDLE, with read|write sampled at a posedge:
  - read has priority when read and write are both high; the write is ignored.
  - Read hit: rdata <= data[index]; go to DONE. Hit latency is 1 cycle (ready high in the cycle after the request is sampled).
  - Read miss: go to WB if WRITE_BACK and the victim is valid and dirty; otherwise go to FILL.
  - Write, WRITE_BACK=1, hit: write the line; dirty=1; go to DONE.
  - Write, WRITE_BACK=1, miss: if the victim is dirty, go to WB first. Then install tag, data=wdata, valid=1, dirty=1, and go to DONE. No fill is needed because lines are one word.
  - Write, WRITE_BACK=0: if hit, update the line (dirty stays 0); go to WT. A miss does not allocate.
- WB: write_mem=1, mem_adbus = victim address, mem_wdata = victim data. On ready_mem&grant_mem: clear dirty, then go to FILL (read) or install and go to DONE (write).
- FILL: read_mem=1 with the request address. On ready_mem&grant_mem: data <= mem_rdata, rdata <= mem_rdata, tag installed, valid=1, dirty=0; go to DONE.
- WT: write_mem=1 with the request address and wdata. On ready_mem&grant_mem go to DONE.
- Memory request signals, mem_adbus and mem_wdata stay stable from assertion until the accepting cycle and deassert in the following cycle.
- ready_mem seen while grant_mem=0 is ignored.
- DONE: ready=1 for exactly one cycle; then go to RELEASE.
- RELEASE: stay until read=0 and write=0 are seen at a posedge, then go to IDLE. This prevents a held request from being serviced twice.
- Counters: a hit increments hit_count and a miss increments miss_count, once per accepted request, in the cycle the request leaves IDLE. Both saturate at all-ones.
- The CPU must hold adbus and wdata stable until ready. Changes made during a miss are not supported.

Decomposition:
- Shared package cache_pkg holds:
  - the state encoding localparams;
  - the address field helper constants (offset width 2);
  - the WRITE_BACK/WRITE_THROUGH policy constants shared with the arbiter bench.
- One sub-module, cache_tag_ram, holds the tag, valid and dirty arrays. Valid and dirty reset asynchronously. It has a single read/write port indexed by index and provides the combinational hit output.
- The data array is inferred inline.

Test Plan:
1. WRITE_BACK=1, cold cache. Write 0x0..0x1C with data=addr → each write is a miss with no memory traffic and ready 1 cycle after the request. miss_count=8.
2. Read 0x0..0x1C → each is a hit with ready in 1 cycle and rdata=addr. No read_mem or write_mem asserted. hit_count=8.
3. Read 0x100 (index 0, tag 1) → WB writes 0x0 to mem_adbus=0x0, then FILL from 0x100. rdata equals the memory content. dirty[0]=0.
4. WRITE_BACK=0. Write 0x4 with data 0xDEAD on a miss → write_mem with mem_adbus=0x4 and mem_wdata=0xDEAD, no allocate. A following read of 0x4 misses and fills 0xDEAD.
5. Hold grant_mem=0 while ready_mem pulses during FILL → no completion. Then grant_mem=1 with ready_mem → completes. CPU holding read for 5 cycles after ready gets no second ready.
6. Assert rst during WB with write_mem=1 → write_mem drops asynchronously, valid is all zero, state=IDLE. The next read of 0x0 is a miss.
